// File: rtl/frame_pingpong_writer.sv
// frame_pingpong_writer: double-buffered LED matrix frame writer; fills the back bank row by row
// and swaps the displayed bank at a display frame boundary.
module frame_pingpong_writer #(
  parameter int ROWS = 7,
  parameter int COLS = 5,
  localparam int ROW_CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_valid,
  input  logic [COLS-1:0]      pix_data,
  output logic                 pix_ready,
  input  logic                 clear,
  input  logic                 swap_ok,
  output logic [ROWS*COLS-1:0] bank0,
  output logic [ROWS*COLS-1:0] bank1,
  output logic                 sel,
  output logic                 disp_en,
  output logic                 frame_done,
  output logic [ROW_CNT_W-1:0] row_idx
);
  typedef enum logic {FILL, WAIT} state_t;
  localparam logic [ROW_CNT_W-1:0] LAST_ROW = ROW_CNT_W'(ROWS - 1);
  state_t state, state_n;
  logic accept, swap, last;
  // clear overrides both the row write and the swap in the same cycle
  always_comb begin
    last = row_idx == LAST_ROW;
    accept = state == FILL && pix_valid && pix_ready && !clear;
    swap = state == WAIT && swap_ok && !clear;
    state_n = clear ? FILL : (accept && last) ? WAIT : swap ? FILL : state;
  end
  always_ff @(posedge clk)
    if (reset) state <= FILL;
    else state <= state_n;
  // writes only ever target the bank not being displayed (~sel)
  always_ff @(posedge clk)
    if (reset) begin
      pix_ready <= 1'b0;
      frame_done <= 1'b0;
      bank0 <= '0;
      bank1 <= '0;
      sel <= 1'b0;
      disp_en <= 1'b0;
      row_idx <= '0;
    end else begin
      pix_ready <= state_n == FILL;
      frame_done <= swap;
      if (clear) row_idx <= '0;
      else if (accept) begin
        if (sel) bank0[row_idx*COLS +: COLS] <= pix_data;
        else bank1[row_idx*COLS +: COLS] <= pix_data;
        row_idx <= last ? row_idx : row_idx + 1'b1;
      end else if (swap) begin
        sel <= ~sel;
        disp_en <= 1'b1;
        row_idx <= '0;
      end
    end
endmodule

// File: tb/tb_frame_pingpong_writer.sv
// tb_frame_pingpong_writer: directed checks of fill, swap hold, ping-pong, clear, gaps and reset.
module tb_frame_pingpong_writer;
  logic clk = 1'b0, reset = 1'b1, pix_valid = 1'b0, clear = 1'b0, swap_ok = 1'b0;
  logic [4:0] pix_data = '0;
  logic pix_ready, sel, disp_en, frame_done;
  logic [34:0] bank0, bank1, exp1, exp2, exp_a, exp_b, exp_c;
  logic [2:0] row_idx;
  logic [4:0] rows1 [7] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F, 5'h00};
  int passed = 0, total = 0;

  frame_pingpong_writer dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .clear(clear), .swap_ok(swap_ok), .bank0(bank0),
    .bank1(bank1), .sel(sel), .disp_en(disp_en), .frame_done(frame_done),
    .row_idx(row_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send(input logic [4:0] d);
    pix_valid = 1'b1;
    pix_data = d;
    tick();
  endtask

  initial begin
    exp1 = {5'h00, 5'h1F, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01};
    for (int r = 0; r < 7; r++) exp2[r*5 +: 5] = 5'(r + 3);
    exp_a = {7{5'h15}};
    exp_b = {7{5'h0A}};
    tick();
    tick();
    chk("rst_ready", pix_ready, 0);
    chk("rst_bank0", bank0, 0);
    chk("rst_bank1", bank1, 0);
    chk("rst_sel", sel, 0);
    chk("rst_disp_en", disp_en, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_row_idx", row_idx, 0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", pix_ready, 1);

    // reset then fill with swap_ok held high
    swap_ok = 1'b1;
    for (int r = 0; r < 7; r++) begin
      send(rows1[r]);
      chk("fill_row_idx", row_idx, (r < 6) ? r + 1 : 6);
      chk("fill_fd", frame_done, 0);
    end
    pix_valid = 1'b0;
    chk("fill_bank1", bank1, exp1);
    chk("fill_bank0", bank0, 0);
    chk("fill_ready_low", pix_ready, 0);
    chk("fill_sel_pre", sel, 0);
    tick();
    chk("fill_sel", sel, 1);
    chk("fill_disp_en", disp_en, 1);
    chk("fill_fd_pulse", frame_done, 1);
    chk("fill_ready_back", pix_ready, 1);
    chk("fill_row_idx0", row_idx, 0);
    swap_ok = 1'b0;
    tick();
    chk("fill_fd_end", frame_done, 0);

    // swap hold: back bank is bank0
    for (int r = 0; r < 7; r++) send(5'(r + 3));
    chk("hold_bank0", bank0, exp2);
    pix_data = 5'h1F;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_ready", pix_ready, 0);
      chk("hold_sel", sel, 1);
      chk("hold_bank0_kept", bank0, exp2);
      chk("hold_bank1_kept", bank1, exp1);
      chk("hold_fd", frame_done, 0);
    end
    pix_valid = 1'b0;
    swap_ok = 1'b1;
    tick();
    chk("hold_swap_sel", sel, 0);
    chk("hold_swap_fd", frame_done, 1);
    swap_ok = 1'b0;
    tick();

    // ping-pong: two back-to-back frames with swap_ok held high
    swap_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send((i < 8) ? 5'h15 : 5'h0A);
      chk("pp_fd", frame_done, (i == 7 || i == 15) ? 1 : 0);
      if (i == 7) begin
        chk("pp_bank1", bank1, exp_a);
        chk("pp_sel1", sel, 1);
      end
    end
    chk("pp_bank0", bank0, exp_b);
    chk("pp_bank1_kept", bank1, exp_a);
    chk("pp_sel0", sel, 0);
    pix_valid = 1'b0;
    swap_ok = 1'b0;
    tick();

    // clear mid-frame: back bank is bank1
    send(5'h01);
    send(5'h02);
    send(5'h03);
    chk("clr_row_idx3", row_idx, 3);
    clear = 1'b1;
    send(5'h1F);
    clear = 1'b0;
    pix_valid = 1'b0;
    exp_c = {{4{5'h15}}, 5'h03, 5'h02, 5'h01};
    chk("clr_row_idx0", row_idx, 0);
    chk("clr_bank1", bank1, exp_c);
    chk("clr_sel", sel, 0);
    chk("clr_ready", pix_ready, 1);
    for (int r = 0; r < 7; r++) send(5'(5'h10 + r));
    pix_valid = 1'b0;
    for (int r = 0; r < 7; r++) exp_c[r*5 +: 5] = 5'(5'h10 + r);
    chk("clr_refill_bank1", bank1, exp_c);
    chk("clr_refill_sel", sel, 0);
    swap_ok = 1'b1;
    tick();
    chk("clr_swap_sel", sel, 1);
    swap_ok = 1'b0;

    // backpressure gaps: valid 1,0,0 into bank0
    for (int i = 0; i < 19; i++) begin
      pix_valid = (i % 3 == 0);
      pix_data = (i % 3 == 0) ? rows1[i / 3] : 5'h1F;
      tick();
      chk("gap_row_idx", row_idx, (i / 3 + 1 > 6) ? 6 : i / 3 + 1);
    end
    pix_valid = 1'b0;
    chk("gap_bank0", bank0, exp1);
    chk("gap_ready", pix_ready, 0);
    chk("gap_sel", sel, 1);

    // reset while waiting with a full back bank
    tick();
    reset = 1'b1;
    swap_ok = 1'b1;
    tick();
    chk("mrst_bank0", bank0, 0);
    chk("mrst_bank1", bank1, 0);
    chk("mrst_sel", sel, 0);
    chk("mrst_disp_en", disp_en, 0);
    chk("mrst_ready", pix_ready, 0);
    chk("mrst_fd", frame_done, 0);
    reset = 1'b0;
    swap_ok = 1'b0;
    tick();
    chk("mrst_ready_up", pix_ready, 1);
    chk("mrst_row_idx", row_idx, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/frame_pingpong_writer.md
# frame_pingpong_writer

Double-buffered frame writer for the 7x5 LED matrix path. It accepts one 5-bit matrix row per valid/ready beat and fills the back bank, which is the bank not selected for display. After 7 rows it waits for a display frame boundary, then swaps banks. Its two bank buses and SEL drive the existing 70-to-35 display multiplexer directly, so it is the writer for that reader.

## Interface
- ROWS, 7, matrix rows per frame; ROW_CNT_W = ceil(log2(ROWS)).
- COLS, 5, bits per row beat.
- CLK  in  1  single clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- PIX_VALID  in  1  upstream row beat valid.
- PIX_DATA  in  COLS  row pixels; bit c = column c.
- PIX_READY  out  1  writer can accept a row; registered.
- CLEAR  in  1  abandon in-progress frame; 1-cycle pulse or level.
- SWAP_OK  in  1  display scanner at frame boundary; level.
- BANK0  out  ROWS*COLS  bank 0 contents; bit r*COLS+c = row r, col c (mux IPT0rc).
- BANK1  out  ROWS*COLS  bank 1 contents, same mapping (mux IPT1rc).
- SEL  out  1  displayed bank (0 = BANK0); mux SEL.
- DISP_EN  out  1  display enable; mux ENABLE.
- FRAME_DONE  out  1  one-cycle pulse on each bank swap.
- ROW_IDX  out  ROW_CNT_W  next row to be written in back bank.

## Operation
- Back bank = ~SEL. Writes never touch the displayed bank.
- States: FILL, WAIT.
- FILL behaviour:
  - PIX_READY=1. Accept = PIX_VALID & PIX_READY.
  - On accept, PIX_DATA goes into the back bank row ROW_IDX and ROW_IDX increments.
  - Accept at ROW_IDX=ROWS-1 goes to WAIT; ROW_IDX holds at ROWS-1.
- WAIT behaviour:
  - PIX_READY=0.
  - SWAP_OK=1 in WAIT causes a swap at the edge: SEL toggles, FRAME_DONE=1 for that cycle, DISP_EN sets to 1 (sticky until reset), ROW_IDX returns to 0, state returns to FILL.
- SWAP_OK is ignored in FILL, including the cycle of the last-row accept. The earliest swap is the edge after entering WAIT.
- CLEAR (FILL or WAIT): state goes to FILL and ROW_IDX to 0. Any same-cycle beat is dropped and no bank bits change. Bank contents, SEL and DISP_EN are kept. Upstream must treat a beat presented with CLEAR as not taken.
- Priority: RESET > CLEAR > swap/accept.
- Rows not rewritten keep old back-bank data. Every frame rewrites all ROWS rows, so no stale data is shown.
- ROW_IDX never exceeds ROWS-1; no wrap occurs inside FILL.

## Timing
- Reset values:
  - state=FILL
  - PIX_READY=0, rising to 1 the first cycle after RESET deasserts
  - BANK0=BANK1=0, SEL=0, DISP_EN=0, FRAME_DONE=0, ROW_IDX=0
- PIX_READY is registered: next value = (next_state==FILL). It falls in the cycle after the last-row accept. It rises in the cycle after the swap or CLEAR.
- Write latency: a row accepted at edge N is visible on BANKx after edge N.
- Swap latency: SWAP_OK sampled high in WAIT at edge N changes SEL, DISP_EN and FRAME_DONE after edge N. The new frame can start being accepted at edge N+1.
- Minimum frame period with continuous VALID and SWAP_OK held high: ROWS+1 cycles (7 accepts + 1 WAIT).
- FRAME_DONE is never high for two consecutive cycles.
- RESET mid-frame: all outputs return to reset values on that edge. The partial frame is lost.

## Test plan
- Reset then fill: 
  - Stimulus: after RESET, send rows 0x01,0x02,0x04,0x08,0x10,0x1F,0x00 with SWAP_OK=1.
  - Required: BANK1 = {0x00,0x1F,0x10,0x08,0x04,0x02,0x01} (row6..row0); BANK0=0; READY low 1 cycle; then SEL=1, DISP_EN=1, FRAME_DONE one pulse.
- Swap hold:
  - Stimulus: fill a frame with SWAP_OK=0 for 10 cycles, then raise it.
  - Required: READY=0 throughout; SEL unchanged; VALID beats ignored with no bank change; swap exactly 1 edge after SWAP_OK rises.
- Ping-pong:
  - Stimulus: two back-to-back frames (all 0x15, then all 0x0A).
  - Required: first frame lands in BANK1, SEL 0→1; second frame lands in BANK0 while BANK1 stays 0x15-filled, SEL 1→0; two FRAME_DONE pulses 8 cycles apart.
- CLEAR mid-frame:
  - Stimulus: 3 rows, then CLEAR asserted together with a VALID beat of 0x1F.
  - Required: ROW_IDX=0; 0x1F not written; rows 0-2 overwritten by the next frame; SEL unchanged.
- Backpressure gaps:
  - Stimulus: PIX_VALID toggled 1,0,0,1,... for a full frame.
  - Required: only valid cycles accepted; ROW_IDX increments per accept; same final bank as the contiguous case.
- Reset mid-operation:
  - Stimulus: RESET asserted in WAIT with a full back bank.
  - Required: next cycle BANK0=BANK1=0, SEL=0, DISP_EN=0, READY=0, then READY=1.
